// File: rtl/lock_sequencer.sv
// lock_sequencer: six-digit combination lock FSM with fail counting, timed lockout and code reprogramming.
module lock_sequencer #(
  parameter int NUM_DIGITS = 6,
  parameter int MAX_FAILS = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter logic [4*NUM_DIGITS-1:0] DEFAULT_CODE = 24'h722297
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  input  logic       clear,
  input  logic       prog_req,
  output logic [2:0] disp_sel,
  output logic [2:0] digit_idx,
  output logic       unlocked,
  output logic       locked_out,
  output logic [1:0] fail_count,
  output logic       digit_err
);
  localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);
  localparam logic [1:0] MAXF = 2'(MAX_FAILS);
  localparam logic [TW-1:0] TLOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0] D_DIGIT = 3'd0, D_ERROR = 3'd1, D_OPEN = 3'd2,
                         D_CLOSED = 3'd3, D_LOCKED = 3'd4, D_PROG = 3'd5;

  typedef enum logic [2:0] {ENTRY, OPEN, CLOSED, LOCKOUT, PROGRAM} state_t;

  state_t state;
  logic [4*NUM_DIGITS-1:0] code, shadow, shadow_next;
  logic [TW-1:0] timer;
  logic mismatch, mm, bad;
  logic [2:0] pos;
  logic [3:0] cur_nib;
  logic [1:0] fail_next;

  // digit 0 lives in the most significant nibble
  always_comb begin
    pos = LAST - digit_idx;
    cur_nib = code[{pos, 2'b00} +: 4];
    mm = mismatch | (digit_in != cur_nib);
    bad = digit_in > 4'd9;
    fail_next = (fail_count == MAXF) ? MAXF : fail_count + 2'd1;
    shadow_next = shadow;
    shadow_next[{pos, 2'b00} +: 4] = digit_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ENTRY;
      digit_idx <= '0;
      mismatch <= 1'b0;
      code <= DEFAULT_CODE;
      shadow <= DEFAULT_CODE;
      fail_count <= '0;
      timer <= '0;
      disp_sel <= D_DIGIT;
      unlocked <= 1'b0;
      locked_out <= 1'b0;
      digit_err <= 1'b0;
    end else begin
      digit_err <= 1'b0;
      case (state)
        ENTRY: begin
          if (clear) begin
            digit_idx <= '0;
            mismatch <= 1'b0;
            disp_sel <= D_DIGIT;
          end else if (digit_valid && bad) begin
            digit_err <= 1'b1;
            disp_sel <= D_ERROR;
          end else if (digit_valid) begin
            disp_sel <= D_DIGIT;
            if (digit_idx == LAST) begin
              digit_idx <= '0;
              mismatch <= 1'b0;
              if (!mm) begin
                state <= OPEN;
                fail_count <= '0;
                disp_sel <= D_OPEN;
                unlocked <= 1'b1;
              end else if (fail_next == MAXF) begin
                state <= LOCKOUT;
                fail_count <= fail_next;
                timer <= TLOAD;
                disp_sel <= D_LOCKED;
                locked_out <= 1'b1;
              end else begin
                state <= CLOSED;
                fail_count <= fail_next;
                disp_sel <= D_CLOSED;
              end
            end else begin
              digit_idx <= digit_idx + 3'd1;
              mismatch <= mm;
            end
          end
        end
        OPEN: begin
          if (clear) begin
            state <= ENTRY;
            digit_idx <= '0;
            mismatch <= 1'b0;
            disp_sel <= D_DIGIT;
            unlocked <= 1'b0;
          end else if (prog_req) begin
            state <= PROGRAM;
            digit_idx <= '0;
            shadow <= code;
            disp_sel <= D_PROG;
          end
        end
        CLOSED: begin
          if (clear) begin
            state <= ENTRY;
            digit_idx <= '0;
            mismatch <= 1'b0;
            disp_sel <= D_DIGIT;
          end
        end
        LOCKOUT: begin
          if (timer == '0) begin
            state <= ENTRY;
            fail_count <= '0;
            digit_idx <= '0;
            mismatch <= 1'b0;
            disp_sel <= D_DIGIT;
            locked_out <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        PROGRAM: begin
          if (clear) begin
            state <= ENTRY;
            digit_idx <= '0;
            mismatch <= 1'b0;
            disp_sel <= D_DIGIT;
            unlocked <= 1'b0;
          end else if (digit_valid && bad) begin
            digit_err <= 1'b1;
            disp_sel <= D_ERROR;
          end else if (digit_valid) begin
            shadow <= shadow_next;
            disp_sel <= D_PROG;
            if (digit_idx == LAST) begin
              code <= shadow_next;
              state <= ENTRY;
              digit_idx <= '0;
              mismatch <= 1'b0;
              disp_sel <= D_DIGIT;
              unlocked <= 1'b0;
            end else begin
              digit_idx <= digit_idx + 3'd1;
            end
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end
endmodule
